// File: rtl/ins_encoder_pkg.sv
// Shared instruction enumeration, field widths and RV32I opcode/funct constants
// used by the micro-op encoder.
package ins_encoder_pkg;

    localparam int OPE_WIDTH        = 6;
    localparam int REG_NUMBER_WIDTH = 5;
    localparam int DATA_WIDTH       = 32;

    typedef enum logic [OPE_WIDTH-1:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        EMPTY_INS
    } ins_type_e;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Emitted in place of any request that cannot be encoded (addi x0,x0,0).
    localparam logic [31:0] NOP_CODE = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic        err;
    } enc_word_t;

    function automatic logic [2:0] funct3_of(logic [OPE_WIDTH-1:0] t);
        logic [2:0] f3;
        f3 = 3'd0;
        case (t)
            BNE, LH, SH, SLLI, SLL:              f3 = 3'd1;
            LW, SW, SLTI, SLT:                   f3 = 3'd2;
            SLTIU, SLTU:                         f3 = 3'd3;
            BLT, LBU, XORI, XOR:                 f3 = 3'd4;
            BGE, LHU, SRLI, SRAI, SRL, SRA:      f3 = 3'd5;
            BLTU, ORI, OR:                       f3 = 3'd6;
            BGEU, ANDI, AND:                     f3 = 3'd7;
            default:                             f3 = 3'd0;
        endcase
        return f3;
    endfunction

    // True when v is representable as a signed value whose sign bit is v[msb].
    function automatic logic fits_signed(logic [31:0] v, int unsigned msb);
        logic [31:0] s;
        s = 32'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/ins_encoder_if.sv
// Request and encoded-word streams between a micro-op producer and the encoder.
interface ins_encoder_if;
    import ins_encoder_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [OPE_WIDTH-1:0]        in_type;
    logic [REG_NUMBER_WIDTH-1:0] in_rd;
    logic [REG_NUMBER_WIDTH-1:0] in_rs1;
    logic [REG_NUMBER_WIDTH-1:0] in_rs2;
    logic [DATA_WIDTH-1:0]       in_imm;
    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_code;
    logic [31:0]                 out_pc;
    logic                        out_err;

    modport master (
        output in_valid, in_type, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_code, out_pc, out_err
    );

    modport slave (
        input  in_valid, in_type, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_code, out_pc, out_err
    );

endinterface

// File: rtl/ins_format_pack.sv
// Combinational packer: micro-op type, registers and decoder-form immediate
// into a 32-bit RV32I word, or NOP with err when the request is not encodable.
module ins_format_pack
    import ins_encoder_pkg::*;
(
    input  logic [OPE_WIDTH-1:0]        ins_type,
    input  logic [REG_NUMBER_WIDTH-1:0] rd,
    input  logic [REG_NUMBER_WIDTH-1:0] rs1,
    input  logic [REG_NUMBER_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]       imm,
    output logic [31:0]                 code,
    output logic                        err
);

    logic [31:0] raw;
    logic        bad;
    logic [2:0]  f3;
    logic [6:0]  f7;

    always_comb begin
        raw = '0;
        bad = 1'b0;
        f3  = funct3_of(ins_type);
        f7  = (ins_type == SUB || ins_type == SRA) ? F7_ALT : F7_BASE;
        case (ins_type)
            LUI: begin
                raw = {imm[19:0], rd, OPC_LUI};
                bad = !fits_signed(imm, 19);
            end
            AUIPC: begin
                raw = {imm[19:0], rd, OPC_AUIPC};
                bad = !fits_signed(imm, 19);
            end
            JAL: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                bad = !fits_signed(imm, 20) || imm[0];
            end
            JALR: begin
                raw = {imm[11:0], rs1, 3'd0, rd, OPC_JALR};
                bad = !fits_signed(imm, 11);
            end
            LB, LH, LW, LBU, LHU: begin
                raw = {imm[11:0], rs1, f3, rd, OPC_LOAD};
                bad = !fits_signed(imm, 11);
            end
            ADDI, SLTI, SLTIU, XORI, ORI, ANDI: begin
                raw = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
                bad = !fits_signed(imm, 11);
            end
            // Shift amount lives in imm[4:0]; imm[11:5] carries the funct7 pattern.
            SLLI, SRLI: begin
                raw = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
                bad = (imm[31:5] != 27'd0);
            end
            SRAI: begin
                raw = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
                bad = (imm[31:5] != 27'h20);
            end
            SB, SH, SW: begin
                raw = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
                bad = !fits_signed(imm, 11);
            end
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
                raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
                bad = !fits_signed(imm, 12) || imm[0];
            end
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: begin
                raw = {f7, rs2, rs1, f3, rd, OPC_OP};
            end
            default: bad = 1'b1;
        endcase
        code = bad ? NOP_CODE : raw;
        err  = bad;
    end

endmodule

// File: rtl/ins_encoder.sv
// Micro-op encoder: packs accepted requests, tags them with a running PC and
// queues them in a 2-entry FIFO toward the instruction-word consumer.
module ins_encoder
    import ins_encoder_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clear_in,
    ins_encoder_if.slave  bus
);

    logic [31:0] pack_code;
    logic        pack_err;
    enc_word_t   mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [31:0] pc;
    logic        push;
    logic        pop;
    enc_word_t   head;

    ins_format_pack u_pack (
        .ins_type (bus.in_type),
        .rd       (bus.in_rd),
        .rs1      (bus.in_rs1),
        .rs2      (bus.in_rs2),
        .imm      (bus.in_imm),
        .code     (pack_code),
        .err      (pack_err)
    );

    // A full FIFO refuses pushes even when the head is leaving this cycle.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign head          = mem[rd_ptr];
    assign bus.out_code  = head.code;
    assign bus.out_pc    = head.pc;
    assign bus.out_err   = head.err;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            pc     <= 32'd0;
        end else if (clear_in) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            pc     <= 32'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{code: pack_code, pc: pc, err: pack_err};
                wr_ptr      <= ~wr_ptr;
                pc          <= pc + 32'd4;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_encoder.sv
// Bench for ins_encoder: scoreboard of expected words checked against an
// independent RV32I field decoder, plus directed vectors and handshake cases.
module tb_ins_encoder;
    import ins_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    ins_encoder_if bus ();

    ins_encoder dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .clear_in (clear),
        .bus      (bus)
    );

    typedef struct {
        logic [5:0]  t;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        err;
        logic        exact;
        logic [31:0] code;
    } exp_t;

    typedef struct {
        logic [5:0]  t;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } dec_t;

    exp_t        sb[$];
    exp_t        cur;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_pc = 32'd0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic byte fmt_of(logic [5:0] t);
        case (t)
            LUI, AUIPC:                              return "U";
            JAL:                                     return "J";
            SB, SH, SW:                              return "S";
            BEQ, BNE, BLT, BGE, BLTU, BGEU:          return "B";
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: return "R";
            default:                                 return "I";
        endcase
    endfunction

    function automatic dec_t decode(logic [31:0] c);
        dec_t d;
        logic [2:0] f3;
        f3 = c[14:12];
        d.t = 6'd63;
        d.rd = c[11:7];
        d.rs1 = c[19:15];
        d.rs2 = c[24:20];
        d.imm = {{20{c[31]}}, c[31:20]};
        case (c[6:0])
            7'h37: begin d.t = LUI;   d.imm = {{12{c[31]}}, c[31:12]}; end
            7'h17: begin d.t = AUIPC; d.imm = {{12{c[31]}}, c[31:12]}; end
            7'h6F: begin
                d.t = JAL;
                d.imm = {{11{c[31]}}, c[31], c[19:12], c[20], c[30:21], 1'b0};
            end
            7'h67: d.t = JALR;
            7'h03: case (f3)
                3'd0: d.t = LB;  3'd1: d.t = LH;  3'd2: d.t = LW;
                3'd4: d.t = LBU; 3'd5: d.t = LHU; default: d.t = 6'd63;
            endcase
            7'h23: begin
                d.imm = {{20{c[31]}}, c[31:25], c[11:7]};
                case (f3)
                    3'd0: d.t = SB; 3'd1: d.t = SH; 3'd2: d.t = SW; default: d.t = 6'd63;
                endcase
            end
            7'h63: begin
                d.imm = {{19{c[31]}}, c[31], c[7], c[30:25], c[11:8], 1'b0};
                case (f3)
                    3'd0: d.t = BEQ; 3'd1: d.t = BNE; 3'd4: d.t = BLT;
                    3'd5: d.t = BGE; 3'd6: d.t = BLTU; 3'd7: d.t = BGEU;
                    default: d.t = 6'd63;
                endcase
            end
            7'h13: case (f3)
                3'd0: d.t = ADDI; 3'd1: d.t = SLLI; 3'd2: d.t = SLTI; 3'd3: d.t = SLTIU;
                3'd4: d.t = XORI; 3'd5: d.t = c[30] ? SRAI : SRLI;
                3'd6: d.t = ORI;  default: d.t = ANDI;
            endcase
            7'h33: case (f3)
                3'd0: d.t = c[30] ? SUB : ADD; 3'd1: d.t = SLL; 3'd2: d.t = SLT;
                3'd3: d.t = SLTU; 3'd4: d.t = XOR; 3'd5: d.t = c[30] ? SRA : SRL;
                3'd6: d.t = OR;   default: d.t = AND;
            endcase
            default: d.t = 6'd63;
        endcase
        return d;
    endfunction

    task automatic check_pop();
        exp_t e;
        dec_t d;
        byte  f;
        if (sb.size() == 0) begin
            chk("unexpected_pop", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("pc", bus.out_pc, e.pc);
        chk("err", 32'(bus.out_err), 32'(e.err));
        if (e.exact) chk("code", bus.out_code, e.code);
        if (!e.err) begin
            d = decode(bus.out_code);
            f = fmt_of(e.t);
            chk("type", 32'(d.t), 32'(e.t));
            if (f != "S" && f != "B") chk("rd", 32'(d.rd), 32'(e.rd));
            if (f != "U" && f != "J") chk("rs1", 32'(d.rs1), 32'(e.rs1));
            if (f == "S" || f == "B" || f == "R") chk("rs2", 32'(d.rs2), 32'(e.rs2));
            if (f != "R") chk("imm", d.imm, e.imm);
        end
    endtask

    // Inputs are already driven; sample handshakes at negedge, then pass the edge.
    task automatic step(output logic acc);
        logic pop;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        pop = bus.out_valid && bus.out_ready;
        if (clear) begin
            sb.delete();
            model_pc = 32'd0;
            acc = 1'b0;
        end else begin
            if (pop) check_pop();
            if (acc) begin
                cur.pc = model_pc;
                sb.push_back(cur);
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cur();
        bus.in_type = cur.t;
        bus.in_rd   = cur.rd;
        bus.in_rs1  = cur.rs1;
        bus.in_rs2  = cur.rs2;
        bus.in_imm  = cur.imm;
    endtask

    task automatic send(input logic [5:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic err,
                        input logic exact, input logic [31:0] code);
        logic acc;
        int   n;
        cur = '{t: t, rd: rd, rs1: rs1, rs2: rs2, imm: imm, pc: 32'd0,
                err: err, exact: exact, code: code};
        drive_cur();
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step(acc);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
    endtask

    function automatic exp_t gen();
        exp_t        e;
        logic [31:0] r;
        r = $urandom;
        e.t = 6'($urandom_range(0, 36));
        e.rd = 5'($urandom);
        e.rs1 = 5'($urandom);
        e.rs2 = 5'($urandom);
        e.pc = 32'd0;
        e.err = 1'b0;
        e.exact = 1'b0;
        e.code = 32'd0;
        case (fmt_of(e.t))
            "U":     e.imm = {{12{r[19]}}, r[19:0]};
            "J":     e.imm = {{11{r[19]}}, r[19:0], 1'b0};
            "B":     e.imm = {{19{r[11]}}, r[11:0], 1'b0};
            "R":     e.imm = r;
            default: e.imm = {{20{r[11]}}, r[11:0]};
        endcase
        if (e.t == SLLI || e.t == SRLI) e.imm = {27'd0, r[4:0]};
        if (e.t == SRAI)                e.imm = {27'h20, r[4:0]};
        return e;
    endfunction

    initial begin
        logic        acc;
        logic [31:0] held;
        int          accepted;
        int          cycles;

        bus.in_valid  = 1'b0;
        bus.in_type   = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_code", bus.out_code, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFF0_0093);
        chk("latency_valid", 32'(bus.out_valid), 32'd1);
        drain();

        send(BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE20_8EE3);
        send(JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b1, 32'h0010_00EF);
        send(SRAI, 5'd5, 5'd5, 5'd0, 32'h403, 1'b0, 1'b1, 32'h4032_D293);
        send(SRAI, 5'd5, 5'd5, 5'd0, 32'h3, 1'b1, 1'b1, NOP_CODE);
        drain();

        // Range boundaries that must encode.
        send(JAL,  5'd3, 5'd0, 5'd0, 32'h000F_FFFE, 1'b0, 1'b0, 32'd0);
        send(JAL,  5'd3, 5'd0, 5'd0, 32'hFFF0_0000, 1'b0, 1'b0, 32'd0);
        send(BEQ,  5'd9, 5'd4, 5'd6, 32'd4094,      1'b0, 1'b0, 32'd0);
        send(BLT,  5'd9, 5'd4, 5'd6, 32'hFFFF_F000, 1'b0, 1'b0, 32'd0);
        send(ADDI, 5'd2, 5'd3, 5'd7, 32'd2047,      1'b0, 1'b0, 32'd0);
        send(LW,   5'd2, 5'd3, 5'd7, 32'hFFFF_F800, 1'b0, 1'b0, 32'd0);
        send(SW,   5'd8, 5'd3, 5'd7, 32'hFFFF_F800, 1'b0, 1'b0, 32'd0);
        send(SLLI, 5'd2, 5'd3, 5'd7, 32'd31,        1'b0, 1'b0, 32'd0);
        send(LUI,  5'd4, 5'd0, 5'd0, 32'hFFF8_0000, 1'b0, 1'b0, 32'd0);
        // Requests that must be rejected as NOP with err.
        send(EMPTY_INS, 5'd1, 5'd1, 5'd1, 32'd0,    1'b1, 1'b1, NOP_CODE);
        send(6'd50, 5'd1, 5'd1, 5'd1, 32'd0,        1'b1, 1'b1, NOP_CODE);
        send(LUI,  5'd4, 5'd0, 5'd0, 32'h0008_0000, 1'b1, 1'b1, NOP_CODE);
        send(JAL,  5'd1, 5'd0, 5'd0, 32'd3,         1'b1, 1'b1, NOP_CODE);
        send(JAL,  5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b1, 1'b1, NOP_CODE);
        send(BEQ,  5'd0, 5'd1, 5'd2, 32'd4096,      1'b1, 1'b1, NOP_CODE);
        send(BNE,  5'd0, 5'd1, 5'd2, 32'd6,         1'b0, 1'b0, 32'd0);
        send(BNE,  5'd0, 5'd1, 5'd2, 32'd5,         1'b1, 1'b1, NOP_CODE);
        send(ADDI, 5'd1, 5'd1, 5'd0, 32'd2048,      1'b1, 1'b1, NOP_CODE);
        send(SW,   5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF, 1'b1, 1'b1, NOP_CODE);
        send(SLLI, 5'd1, 5'd1, 5'd0, 32'd32,        1'b1, 1'b1, NOP_CODE);
        send(SRLI, 5'd1, 5'd1, 5'd0, 32'h405,       1'b1, 1'b1, NOP_CODE);
        drain();

        // Synchronous clear drops the stored entry and the same-cycle push.
        bus.out_ready = 1'b0;
        send(ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        cur = gen();
        drive_cur();
        bus.in_valid = 1'b1;
        clear = 1'b1;
        step(acc);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clear_in_ready", 32'(bus.in_ready), 32'd1);

        // Backpressure: two accepted, third refused until the consumer drains.
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b0, 32'd0);
        send(ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 1'b0, 32'd0);
        cur = '{t: ADDI, rd: 5'd3, rs1: 5'd0, rs2: 5'd0, imm: 32'd3, pc: 32'd0,
                err: 1'b0, exact: 1'b0, code: 32'd0};
        drive_cur();
        bus.in_valid = 1'b1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        held = bus.out_code;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            if (acc) chk("accepted_while_full", 32'd1, 32'd0);
        end
        chk("hold_code", bus.out_code, held);
        chk("hold_pc", bus.out_pc, 32'd0);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        if (!acc) chk("third_accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // Asynchronous reset with a full FIFO under backpressure.
        bus.out_ready = 1'b0;
        send(XOR, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        send(OR,  5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst_pc", bus.out_pc, 32'd0);
        sb.delete();
        model_pc = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFF0_0093);
        drain();

        // Random legal traffic with random stalls on both sides.
        accepted = 0;
        cycles = 0;
        cur = gen();
        drive_cur();
        while (accepted < 10000 && cycles < 40000) begin
            bus.in_valid  = ($urandom_range(0, 4) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            cycles++;
            if (acc) begin
                accepted++;
                cur = gen();
                drive_cur();
            end
        end
        if (accepted < 10000) chk("random_budget", 32'(accepted), 32'd10000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
